// File: rtl/apb2_requester.sv
// apb2_requester: APB2 initiator turning a single command/response handshake into SETUP/ACCESS transfers
//   i_pclk, i_preset        clock and asynchronous active-high reset
//   i_cmd_* / o_cmd_ready   host command (write, byte address, data, strobes, prot)
//   o_rsp_* / i_rsp_ready   host response (read data, error, timeout cause)
//   o_p* / i_p*             APB2 requester bus
// Misaligned commands are answered with an error without touching the bus;
// a completer that holds pready low for timeout_cycles ACCESS cycles is abandoned.
module apb2_requester #(
    parameter int data_width     = 32,
    parameter int addr_width     = 8,
    parameter int timeout_cycles = 256,
    parameter int timeout_width  = $clog2(timeout_cycles) + 1
) (
    input  logic                    i_pclk,
    input  logic                    i_preset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [addr_width-1:0]   i_cmd_addr,
    input  logic [data_width-1:0]   i_cmd_wdata,
    input  logic [data_width/8-1:0] i_cmd_strb,
    input  logic [2:0]              i_cmd_prot,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [data_width-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,
    output logic                    o_psel,
    output logic                    o_penable,
    output logic                    o_pwrite,
    output logic [addr_width-1:0]   o_paddr,
    output logic [data_width-1:0]   o_pwdata,
    output logic [data_width/8-1:0] o_pstrb,
    output logic [2:0]              o_pprot,
    input  logic [data_width-1:0]   i_prdata,
    input  logic                    i_pready,
    input  logic                    i_pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [timeout_width-1:0] c_limit = timeout_width'(timeout_cycles - 1);

    state_t                    r_state, w_next;
    logic                      r_cmd_ready, r_rsp_valid, r_rsp_err, r_rsp_timeout;
    logic                      r_psel, r_penable, r_pwrite;
    logic [addr_width-1:0]     r_paddr;
    logic [data_width-1:0]     r_pwdata, r_rsp_rdata;
    logic [data_width/8-1:0]   r_pstrb;
    logic [2:0]                r_pprot;
    logic [timeout_width-1:0]  r_cnt;
    logic                      w_accept, w_misaligned, w_done, w_timeout;

    assign w_accept     = (r_state == IDLE) && i_cmd_valid;
    assign w_misaligned = i_cmd_addr[1:0] != 2'b00;
    assign w_done       = (r_state == ACCESS) && i_pready;
    // pready on the limit cycle is a normal completion, never a timeout
    assign w_timeout    = (r_state == ACCESS) && !i_pready && (r_cnt == c_limit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_cmd_valid ? (w_misaligned ? RESP : SETUP) : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (w_done || w_timeout) ? RESP : ACCESS;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Every interface output is a flop loaded from the next state, so nothing
    // on the APB side reaches the host side combinationally.
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_cnt         <= '0;
        end else begin
            r_cmd_ready <= w_next == IDLE;
            r_rsp_valid <= w_next == RESP;
            r_psel      <= (w_next == SETUP) || (w_next == ACCESS);
            r_penable   <= w_next == ACCESS;
            // A rejected command leaves the bus outputs untouched
            if (w_accept && !w_misaligned) begin
                r_pwrite <= i_cmd_write;
                r_paddr  <= i_cmd_addr;
                r_pwdata <= i_cmd_wdata;
                r_pstrb  <= i_cmd_write ? i_cmd_strb : '0;
                r_pprot  <= i_cmd_prot;
            end
            if (r_state != ACCESS) r_cnt <= '0;
            else if (!i_pready)    r_cnt <= r_cnt + 1'b1;
            if (w_accept && w_misaligned) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b0;
            end else if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : i_prdata;
                r_rsp_err     <= i_pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end else if ((r_state == RESP) && i_rsp_ready) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b0;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign o_cmd_ready   = r_cmd_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_pwrite;
    assign o_paddr       = r_paddr;
    assign o_pwdata      = r_pwdata;
    assign o_pstrb       = r_pstrb;
    assign o_pprot       = r_pprot;
endmodule

// File: tb/tb_apb2_requester.sv
// tb_apb2_requester: directed bench with a response scoreboard for apb2_requester
module tb_apb2_requester;
    localparam int tmo = 4;

    logic        clk, preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    apb2_requester #(.data_width(32), .addr_width(8), .timeout_cycles(tmo)) dut (
        .i_pclk(clk), .i_preset(preset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_strb(cmd_strb), .i_cmd_prot(cmd_prot),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
        .o_pwdata(pwdata), .o_pstrb(pstrb), .o_pprot(pprot),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One host transfer; the completer answers after 'waits' wait states
    // (never, if waits >= tmo) and the host delays rsp_ready by 'hold' cycles.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic [31:0] rd,
                        input logic se, input int hold);
        logic mis, to;
        int   acc;
        rsp_t e;
        mis = addr[1:0] != 2'b00;
        to  = !mis && (waits >= tmo);
        e.err   = mis || to || se;
        e.to    = to;
        e.rdata = (mis || to || wr) ? 32'h0 : rd;
        q.push_back(e);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        cmd_strb = st; cmd_prot = 3'b101;
        prdata = rd; pslverr = se; pready = 1'b0;
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (mis) begin
            chk("mis_psel", {31'h0, psel}, 32'h0);
            chk("mis_rsp_valid_latency", {31'h0, rsp_valid}, 32'h1);
        end else begin
            chk("setup_sel_en", {30'h0, psel, penable}, 32'h2);
            chk("setup_paddr", {24'h0, paddr}, {24'h0, addr});
            chk("setup_pwrite", {31'h0, pwrite}, {31'h0, wr});
            chk("setup_pwdata", pwdata, wd);
            chk("setup_pstrb", {28'h0, pstrb}, {28'h0, wr ? st : 4'h0});
            chk("setup_pprot", {29'h0, pprot}, 32'h5);
            chk("setup_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            acc = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (!(psel && penable)) break;
                acc++;
                if (paddr !== addr || pwdata !== wd || rsp_valid !== 1'b0)
                    chk("access_stable", {pwdata ^ wd} | {24'h0, paddr ^ addr} | {31'h0, rsp_valid}, 32'h0);
                pready = (k == waits);
            end
            pready = 1'b0;
            chk("access_cycles", acc, to ? tmo : waits + 1);
            chk("resp_sel_en", {30'h0, psel, penable}, 32'h0);
            chk("resp_paddr_held", {24'h0, paddr}, {24'h0, addr});
            chk("rsp_valid_arrives", {31'h0, rsp_valid}, 32'h1);
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_state", {rsp_rdata[29:0], rsp_err, rsp_valid & ~cmd_ready}, {e.rdata[29:0], e.err, 1'b1});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.to});
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drops", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    endtask

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #12;
        chk("reset_outputs", {26'h0, psel, penable, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 32'h1);
        chk("reset_paddr", {24'h0, paddr}, 32'h0);
        @(negedge clk);
        preset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'h0, cmd_ready}, 32'h1);

        xfer(1'b1, 8'h10, 32'h0000000B, 4'hF, 0, 32'hCAFEF00D, 1'b0, 0);
        xfer(1'b0, 8'h04, 32'h11111111, 4'hF, 3, 32'h12345678, 1'b0, 0);
        xfer(1'b0, 8'h14, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b1, 1);
        xfer(1'b0, 8'h20, 32'h0,        4'h0, 99, 32'h55555555, 1'b0, 0);
        xfer(1'b1, 8'h24, 32'hA0B1C2D3, 4'h6, 2, 32'h0,        1'b0, 0);
        xfer(1'b0, 8'h06, 32'h0,        4'h0, 0, 32'h77777777, 1'b0, 5);
        xfer(1'b0, 8'h08, 32'h0,        4'h0, tmo - 1, 32'hA5A5A5A5, 1'b0, 0);
        xfer(1'b1, 8'h01, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1, 2);

        // Reset while a read waits in ACCESS: the transfer vanishes without a response
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; pready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_access", {30'h0, psel, penable}, 32'h3);
        #2 preset = 1'b1;
        #1 chk("async_reset", {29'h0, psel, penable, rsp_valid}, 32'h0);
        chk("async_reset_ready", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        preset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_rsp", {29'h0, rsp_valid, psel, cmd_ready}, 32'h1);
        end
        xfer(1'b0, 8'h3C, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 0);
        chk("scoreboard_empty", q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb2_requester.md
Name: apb2_requester

Overview:
- APB2 requester (initiator) that turns a single-entry command/response handshake into APB2 SETUP/ACCESS transfers.
- Sits between a host-side controller (sequencer, debug UART bridge, test harness) and APB completers such as the BLDC peripheral register block.
- Provides a per-transfer wait-state timeout and misaligned-address rejection, so a hung or absent completer never stalls the host.

Parameters:
- data_width, 32, APB data width; must be a multiple of 8.
- addr_width, 8, APB address width.
- timeout_cycles, 256, max ACCESS-phase cycles waiting for pready before abort; must be at least 1.
- timeout_width, $clog2(timeout_cycles)+1, width of the wait counter (derived).

Ports:
- pclk  in  1  single clock for all logic and the APB bus.
- preset  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  requester can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addr_width  byte address.
- cmd_wdata  in  data_width  write data.
- cmd_strb  in  data_width/8  write byte strobes.
- cmd_prot  in  3  protection attributes forwarded to pprot.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_rdata  out  data_width  read data; 0 for writes.
- rsp_err  out  1  pslverr, timeout or misalignment.
- rsp_timeout  out  1  error cause was a timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  addr_width  APB address.
- pwdata  out  data_width  APB write data.
- pstrb  out  data_width/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  data_width  APB read data.
- pready  in  1  completer ready.
- pslverr  in  1  completer error.

Behaviour:
- Reset (async, preset=1) forces all outputs to 0 except cmd_ready, and sets state to IDLE. This applies immediately and from any state.
  - After reset, cmd_ready=1 once preset deasserts.
  - A transfer in flight when reset asserts is dropped and produces no response.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On cmd_valid & cmd_ready: register write/addr/wdata/prot, and register strb masked to 0 for reads.
  - Misalignment check: if cmd_addr[1:0] != 0, go to RESP directly with rsp_err=1, rsp_timeout=0 and rsp_rdata=0. No APB activity occurs.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, and paddr/pwrite/pwdata/pstrb/pprot driven from the registered command. Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1, all address/control/data outputs held stable.
  - pready, prdata and pslverr are sampled only here.
  - On pready=1: capture rsp_rdata = prdata for reads (0 for writes), rsp_err = pslverr, rsp_timeout = 0, then go to RESP.
  - Wait counter: cleared on entry to ACCESS, increments each ACCESS cycle with pready=0.
  - Timeout: when the counter reaches timeout_cycles with pready still 0, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If pready=1 arrives in the same cycle the counter hits the limit, pready wins (normal completion).
- RESP:
  - psel=0 and penable=0 on the first RESP cycle.
  - paddr/pwdata/pstrb/pwrite/pprot retain their last values.
  - rsp_valid=1 with rsp_* stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: return to IDLE; rsp_valid drops next cycle.
- Latency:
  - Command accept to psel rise: 1 cycle.
  - Zero-wait-state transfer: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3.
  - Best-case command-to-command spacing is 4 cycles (rsp_ready held high).
- Back-to-back: a new command cannot be accepted while a response is pending; cmd_ready is 0 in SETUP, ACCESS and RESP.
- psel and penable never assert simultaneously outside ACCESS. penable is never 1 while psel=0.
- All outputs are registered; there are no combinational paths from APB inputs to the command or response interface.

Test Plan:
- Write addr 0x10, wdata 0x0000000B, strb 0xF, completer pready=1 immediately -> psel rises 1 cycle after accept, penable 1 cycle later; paddr=0x10, pwdata=0x0B held through ACCESS; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read addr 0x04, completer inserts 3 wait states then returns prdata=0x12345678 -> penable high for 4 cycles, pstrb=0; rsp_rdata=0x12345678, rsp_err=0.
- Read addr 0x14, completer asserts pslverr=1 with pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- timeout_cycles=4, pready held 0 -> ACCESS lasts 4 cycles, psel/penable drop; rsp_err=1, rsp_timeout=1; next command is accepted normally after rsp_ready.
- cmd_addr=0x06 -> psel never asserts; rsp_valid 1 cycle after accept with rsp_err=1, rsp_timeout=0. Also: rsp_ready held 0 for 5 cycles -> rsp stable, cmd_ready=0 throughout.
- Assert preset during ACCESS with pready=0 -> psel, penable and rsp_valid go to 0 asynchronously; after release cmd_ready=1 and no stale response is emitted.
